xbar_slave_arbiter: RTL and testbench

Per-slave arbiter and sequencer that shares one crossbar slave port among MASTERS requesters. Each master has a one-entry transaction cell. A rotating-priority pick selects the next cell, and an FSM drives the slave req/ack/resp handshake. A watchdog converts a hung slave into an error response. One instance sits on each slave leg of the crossbar and replaces the fixed-offset pointer scan.

---
 rtl/xbar_pkg.sv | 27 ++
 rtl/xbar_rr_pick.sv | 38 +++
 rtl/xbar_slave_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_xbar_slave_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared types and constants for the crossbar slave-leg arbiter.
//   tx_cell_t   : one-entry per-master transaction cell
//   arb_state_e : sequencer states for the slave handshake
//   CMD_READ / CMD_WRITE : command encodings on m_cmd / s_cmd
package xbar_pkg;

  localparam int unsigned XBAR_DATA_W   = 32;
  // Slave-local addresses never exceed the full 32-bit bus width.
  localparam int unsigned XBAR_ADDR_MAX = 32;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RESP
  } arb_state_e;

  typedef struct packed {
    logic                     valid;
    logic                     cmd;
    logic [XBAR_ADDR_MAX-1:0] addr;
    logic [XBAR_DATA_W-1:0]   data;
  } tx_cell_t;

endpackage

// File: rtl/xbar_rr_pick.sv
// Combinational rotating-priority encoder.
//   i_valid : request vector, one bit per requester
//   i_ptr   : index of the last winner; search starts at i_ptr+1
//   o_any   : at least one valid bit
//   o_idx   : first valid index found searching i_ptr+1, i_ptr+2, ... mod N
module xbar_rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);

  localparam int unsigned CW = IW + 1;

  logic [CW-1:0] w_cand;

  // Modulo is done with an explicit subtract so that non-power-of-2 N wraps
  // correctly; the extra bit holds ptr+k before the wrap.
  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = {1'b0, i_ptr} + CW'(k);
      if (w_cand >= CW'(N)) begin
        w_cand = w_cand - CW'(N);
      end
      if (!o_any && i_valid[w_cand[IW-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave arbiter and sequencer sharing one crossbar slave port among
// MASTERS requesters, each with a one-entry transaction cell.
//   clk, rst        : clock, synchronous active-high reset
//   m_req/cmd/addr/wdata : per-master request (addr/wdata flattened, master i
//                     at [i*W +: W])
//   m_full          : cell occupied
//   m_ack/resp/err  : one-cycle, one-hot per-master strobes; err qualifies resp
//   m_rdata         : read data, valid with any m_resp bit, held otherwise
//   s_req/cmd/addr/wdata : request to the slave (s_req is a one-cycle pulse)
//   s_ack/resp/rdata: slave handshake and read data
//   spurious_cnt    : saturating count of unexpected s_ack/s_resp strobes
module xbar_slave_arbiter
  import xbar_pkg::*;
#(
  parameter int unsigned MASTERS = 4,
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MASTERS-1:0]        m_req,
  input  logic [MASTERS-1:0]        m_cmd,
  input  logic [MASTERS*ADDR_W-1:0] m_addr,
  input  logic [MASTERS*32-1:0]     m_wdata,
  output logic [MASTERS-1:0]        m_full,
  output logic [MASTERS-1:0]        m_ack,
  output logic [MASTERS-1:0]        m_resp,
  output logic [MASTERS-1:0]        m_err,
  output logic [31:0]               m_rdata,
  output logic                      s_req,
  output logic                      s_cmd,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [31:0]               s_wdata,
  input  logic                      s_ack,
  input  logic                      s_resp,
  input  logic [31:0]               s_rdata,
  output logic [7:0]                spurious_cnt
);

  localparam int unsigned IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT);

  arb_state_e          r_state, w_state_nx;
  tx_cell_t            r_cell [MASTERS];
  logic [IDX_W-1:0]    r_rr_ptr, r_grant;
  logic [WD_W-1:0]     r_wd;
  logic                r_resp_latched;
  logic [31:0]         r_latched_rdata;
  logic                r_s_req, r_s_cmd;
  logic [ADDR_W-1:0]   r_s_addr;
  logic [31:0]         r_s_wdata, r_m_rdata;
  logic [MASTERS-1:0]  r_m_ack, r_m_resp, r_m_err;
  logic [7:0]          r_spur;

  logic [MASTERS-1:0]  w_valid;
  logic                w_any;
  logic [IDX_W-1:0]    w_pick;
  logic                w_issue, w_ack_ev, w_resp_ev, w_tmo, w_latch;
  logic                w_spur_ack, w_spur_resp;
  logic [31:0]         w_resp_data;
  logic [8:0]          w_spur_sum;
  logic [7:0]          w_spur_nx;
  logic                w_wd_expired;

  always_comb begin
    w_valid = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      w_valid[i] = r_cell[i].valid;
    end
  end

  xbar_rr_pick #(.N(MASTERS)) u_pick (
    .i_valid (w_valid),
    .i_ptr   (r_rr_ptr),
    .o_any   (w_any),
    .o_idx   (w_pick)
  );

  assign w_wd_expired = (r_wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // An ack that arrives together with resp is taken as the ack only; the resp
  // is parked in r_resp_latched and delivered from WAIT_RESP one cycle later,
  // so the granted master always sees m_ack before m_resp.
  always_comb begin
    w_state_nx  = r_state;
    w_issue     = 1'b0;
    w_ack_ev    = 1'b0;
    w_resp_ev   = 1'b0;
    w_tmo       = 1'b0;
    w_latch     = 1'b0;
    w_spur_ack  = s_ack;
    w_spur_resp = s_resp;
    w_resp_data = s_rdata;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_issue    = 1'b1;
          w_state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        w_spur_ack  = 1'b0;
        w_spur_resp = 1'b0;
        if (s_ack) begin
          w_ack_ev   = 1'b1;
          w_latch    = s_resp;
          w_state_nx = WAIT_RESP;
        end else if (w_wd_expired) begin
          w_tmo      = 1'b1;
          w_state_nx = IDLE;
        end
      end
      WAIT_RESP: begin
        w_spur_resp = 1'b0;
        if (r_resp_latched) begin
          w_resp_ev   = 1'b1;
          w_resp_data = r_latched_rdata;
          w_spur_resp = s_resp;
          w_state_nx  = IDLE;
        end else if (s_resp) begin
          w_resp_ev  = 1'b1;
          w_state_nx = IDLE;
        end else if (w_wd_expired) begin
          w_tmo      = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_spur_sum = {1'b0, r_spur} + {8'b0, w_spur_ack} + {8'b0, w_spur_resp};
  assign w_spur_nx  = w_spur_sum[8] ? 8'hFF : w_spur_sum[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MASTERS; i++) begin
        r_cell[i] <= '0;
      end
      r_rr_ptr        <= IDX_W'(MASTERS - 1);
      r_grant         <= '0;
      r_wd            <= '0;
      r_resp_latched  <= 1'b0;
      r_latched_rdata <= '0;
      r_s_req         <= 1'b0;
      r_s_cmd         <= 1'b0;
      r_s_addr        <= '0;
      r_s_wdata       <= '0;
      r_m_rdata       <= '0;
      r_m_ack         <= '0;
      r_m_resp        <= '0;
      r_m_err         <= '0;
      r_spur          <= '0;
    end else begin
      r_s_req  <= 1'b0;
      r_m_ack  <= '0;
      r_m_resp <= '0;
      r_m_err  <= '0;

      for (int unsigned i = 0; i < MASTERS; i++) begin
        if (m_req[i] && !r_cell[i].valid) begin
          r_cell[i].valid <= 1'b1;
          r_cell[i].cmd   <= m_cmd[i];
          r_cell[i].addr  <= XBAR_ADDR_MAX'(m_addr[i*ADDR_W +: ADDR_W]);
          r_cell[i].data  <= m_wdata[i*32 +: 32];
        end
      end

      if (w_issue) begin
        r_cell[w_pick].valid <= 1'b0;
        r_rr_ptr             <= w_pick;
        r_grant              <= w_pick;
        r_s_req              <= 1'b1;
        r_s_cmd              <= r_cell[w_pick].cmd;
        r_s_addr             <= r_cell[w_pick].addr[ADDR_W-1:0];
        if (r_cell[w_pick].cmd == CMD_WRITE) begin
          r_s_wdata <= r_cell[w_pick].data;
        end
        r_wd <= '0;
      end else if (r_state != IDLE) begin
        r_wd <= r_wd + WD_W'(1);
      end

      if (w_ack_ev) begin
        r_m_ack[r_grant] <= 1'b1;
        r_wd             <= '0;
        r_resp_latched   <= w_latch;
        r_latched_rdata  <= s_rdata;
      end

      if (w_resp_ev) begin
        r_m_resp[r_grant] <= 1'b1;
        r_m_rdata         <= (r_s_cmd == CMD_WRITE) ? '0 : w_resp_data;
        r_resp_latched    <= 1'b0;
      end

      if (w_tmo) begin
        r_m_resp[r_grant] <= 1'b1;
        r_m_err[r_grant]  <= 1'b1;
        r_m_rdata         <= '0;
      end

      r_spur <= w_spur_nx;
    end
  end

  assign m_full       = w_valid;
  assign m_ack        = r_m_ack;
  assign m_resp       = r_m_resp;
  assign m_err        = r_m_err;
  assign m_rdata      = r_m_rdata;
  assign s_req        = r_s_req;
  assign s_cmd        = r_s_cmd;
  assign s_addr       = r_s_addr;
  assign s_wdata      = r_s_wdata;
  assign spurious_cnt = r_spur;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Directed self-checking bench for xbar_slave_arbiter (4 masters, TIMEOUT=8).
module tb_xbar_slave_arbiter;

  localparam int unsigned M  = 4;
  localparam int unsigned AW = 30;
  localparam int unsigned TO = 8;

  logic            clk;
  logic            rst;
  logic [M-1:0]    m_req, m_cmd;
  logic [M*AW-1:0] m_addr;
  logic [M*32-1:0] m_wdata;
  logic [M-1:0]    m_full, m_ack, m_resp, m_err;
  logic [31:0]     m_rdata;
  logic            s_req, s_cmd;
  logic [AW-1:0]   s_addr;
  logic [31:0]     s_wdata;
  logic            s_ack, s_resp;
  logic [31:0]     s_rdata;
  logic [7:0]      spurious_cnt;

  int total;
  int bad;

  xbar_slave_arbiter #(.MASTERS(M), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .m_req        (m_req),
    .m_cmd        (m_cmd),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_full       (m_full),
    .m_ack        (m_ack),
    .m_resp       (m_resp),
    .m_err        (m_err),
    .m_rdata      (m_rdata),
    .s_req        (s_req),
    .s_cmd        (s_cmd),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_ack        (s_ack),
    .s_resp       (s_resp),
    .s_rdata      (s_rdata),
    .spurious_cnt (spurious_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; m_req = '0; s_ack = 1'b0; s_resp = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_req = 4'hF; m_cmd = '0;
    tick();
    tick();
    total++; if (m_full !== 4'h0) begin bad++; $display("FAIL reset_full got=%h exp=0", m_full); end
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL reset_sreq got=%b exp=0", s_req); end
    total++; if ({m_ack, m_resp, m_err} !== 12'h0) begin bad++; $display("FAIL reset_strobes got=%h exp=0", {m_ack, m_resp, m_err}); end
    total++; if (m_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", m_rdata); end
    total++; if (spurious_cnt !== 8'h0) begin bad++; $display("FAIL reset_spur got=%0d exp=0", spurious_cnt); end
    m_req = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    apply_reset();
    m_req = 4'b0100; m_cmd = '0; m_addr[2*AW +: AW] = 30'h10;
    tick();
    m_req = '0;
    total++; if (m_full !== 4'b0100) begin bad++; $display("FAIL rd_full got=%h exp=4", m_full); end
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL rd_early_sreq got=%b exp=0", s_req); end
    tick();
    total++; if (s_req !== 1'b1) begin bad++; $display("FAIL rd_sreq got=%b exp=1", s_req); end
    total++; if (s_addr !== 30'h10) begin bad++; $display("FAIL rd_saddr got=%h exp=10", s_addr); end
    total++; if (s_cmd !== 1'b0) begin bad++; $display("FAIL rd_scmd got=%b exp=0", s_cmd); end
    total++; if (m_full !== 4'h0) begin bad++; $display("FAIL rd_freed got=%h exp=0", m_full); end
    tick();
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL rd_sreq_pulse got=%b exp=0", s_req); end
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    total++; if (m_ack !== 4'b0100) begin bad++; $display("FAIL rd_mack got=%h exp=4", m_ack); end
    total++; if (m_resp !== 4'h0) begin bad++; $display("FAIL rd_early_resp got=%h exp=0", m_resp); end
    tick();
    total++; if (m_ack !== 4'h0) begin bad++; $display("FAIL rd_mack_pulse got=%h exp=0", m_ack); end
    tick();
    s_resp = 1'b1; s_rdata = 32'hDEADBEEF;
    tick();
    s_resp = 1'b0; s_rdata = 32'h0;
    total++; if (m_resp !== 4'b0100) begin bad++; $display("FAIL rd_mresp got=%h exp=4", m_resp); end
    total++; if (m_err !== 4'h0) begin bad++; $display("FAIL rd_merr got=%h exp=0", m_err); end
    total++; if (m_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got=%h exp=deadbeef", m_rdata); end
    tick();
    total++; if (m_resp !== 4'h0) begin bad++; $display("FAIL rd_mresp_pulse got=%h exp=0", m_resp); end
    total++; if (m_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata_hold got=%h exp=deadbeef", m_rdata); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    m_req = 4'b0011; m_cmd = '0;
    m_addr[0*AW +: AW] = 30'h40;
    m_addr[1*AW +: AW] = 30'h41;
    tick();
    m_req = '0;
    tick();
    total++; if (s_req !== 1'b1 || s_addr !== 30'h40) begin bad++; $display("FAIL b2b_issue0 got=%b/%h exp=1/40", s_req, s_addr); end
    s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'h11111111;
    tick();
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = 32'h99999999;
    total++; if (m_ack !== 4'b0001) begin bad++; $display("FAIL b2b_comb_ack got=%h exp=1", m_ack); end
    total++; if (m_resp !== 4'h0) begin bad++; $display("FAIL b2b_comb_noresp got=%h exp=0", m_resp); end
    tick();
    total++; if (m_resp !== 4'b0001) begin bad++; $display("FAIL b2b_comb_resp got=%h exp=1", m_resp); end
    total++; if (m_rdata !== 32'h11111111) begin bad++; $display("FAIL b2b_comb_rdata got=%h exp=11111111", m_rdata); end
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b exp=0", s_req); end
    tick();
    total++; if (s_req !== 1'b1 || s_addr !== 30'h41) begin bad++; $display("FAIL b2b_issue1 got=%b/%h exp=1/41", s_req, s_addr); end
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    total++; if (m_ack !== 4'b0010) begin bad++; $display("FAIL b2b_ack1 got=%h exp=2", m_ack); end
    s_resp = 1'b1; s_rdata = 32'h22222222;
    tick();
    s_resp = 1'b0;
    total++; if (m_resp !== 4'b0010 || m_rdata !== 32'h22222222) begin bad++; $display("FAIL b2b_resp1 got=%h/%h exp=2/22222222", m_resp, m_rdata); end
  endtask

  task automatic test_fairness();
    int n;
    int nr;
    apply_reset();
    for (int ph = 0; ph < 2; ph++) begin
      m_req = 4'hF; m_cmd = '0;
      for (int i = 0; i < 4; i++) begin
        m_addr[i*AW +: AW] = AW'(32'h100 + ph*16 + i);
      end
      tick();
      m_req = '0;
      total++; if (m_full !== 4'hF) begin bad++; $display("FAIL fair_loaded ph=%0d got=%h exp=f", ph, m_full); end
      n = 0;
      nr = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        tick();
        if (m_ack !== 4'h0) begin
          total++; if (m_ack !== (4'b0001 << n)) begin bad++; $display("FAIL fair_order ph=%0d got=%h exp=%h", ph, m_ack, 4'b0001 << n); end
          total++; if (s_addr !== AW'(32'h100 + ph*16 + n)) begin bad++; $display("FAIL fair_addr ph=%0d got=%h exp=%h", ph, s_addr, 32'h100 + ph*16 + n); end
          n++;
        end
        if (m_resp !== 4'h0) begin
          total++; if (m_rdata !== (32'hCAFE0000 | (nr + 1))) begin bad++; $display("FAIL fair_rdata ph=%0d got=%h exp=%h", ph, m_rdata, 32'hCAFE0000 | (nr + 1)); end
          nr++;
        end
        s_ack   = s_req;
        s_resp  = (m_ack !== 4'h0);
        s_rdata = 32'hCAFE0000 | n;
        if (nr == 4) break;
      end
      s_ack = 1'b0; s_resp = 1'b0;
      total++; if (n != 4 || nr != 4) begin bad++; $display("FAIL fair_count ph=%0d got=%0d/%0d exp=4/4", ph, n, nr); end
    end
  endtask

  task automatic test_full_cell();
    int reqs;
    reqs = 0;
    m_req = 4'b0010; m_cmd = 4'b0010;
    m_addr[1*AW +: AW] = 30'h1A1; m_wdata[1*32 +: 32] = 32'h1111AAAA;
    tick();
    if (s_req === 1'b1) reqs++;
    total++; if (m_full !== 4'b0010) begin bad++; $display("FAIL full_flag got=%h exp=2", m_full); end
    m_addr[1*AW +: AW] = 30'h1A2; m_wdata[1*32 +: 32] = 32'h2222BBBB;
    tick();
    if (s_req === 1'b1) reqs++;
    m_req = '0;
    total++; if (s_req !== 1'b1 || s_addr !== 30'h1A1) begin bad++; $display("FAIL full_issue got=%b/%h exp=1/1a1", s_req, s_addr); end
    total++; if (s_wdata !== 32'h1111AAAA || s_cmd !== 1'b1) begin bad++; $display("FAIL full_wdata got=%h/%b exp=1111aaaa/1", s_wdata, s_cmd); end
    total++; if (m_full !== 4'h0) begin bad++; $display("FAIL full_ignored got=%h exp=0", m_full); end
    s_ack = 1'b1;
    tick();
    if (s_req === 1'b1) reqs++;
    s_ack = 1'b0;
    total++; if (m_ack !== 4'b0010) begin bad++; $display("FAIL full_ack got=%h exp=2", m_ack); end
    s_resp = 1'b1; s_rdata = 32'hBAD0BAD0;
    tick();
    if (s_req === 1'b1) reqs++;
    s_resp = 1'b0;
    total++; if (m_resp !== 4'b0010 || m_rdata !== 32'h0) begin bad++; $display("FAIL full_wr_resp got=%h/%h exp=2/0", m_resp, m_rdata); end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (s_req === 1'b1) reqs++;
    end
    total++; if (reqs != 1) begin bad++; $display("FAIL full_one_sreq got=%0d exp=1", reqs); end
  endtask

  task automatic test_timeout();
    apply_reset();
    m_req = 4'b0101; m_cmd = '0;
    m_addr[0*AW +: AW] = 30'h20;
    m_addr[2*AW +: AW] = 30'h22;
    tick();
    m_req = '0; s_rdata = 32'h55555555;
    tick();
    total++; if (s_req !== 1'b1 || s_addr !== 30'h20) begin bad++; $display("FAIL to_issue0 got=%b/%h exp=1/20", s_req, s_addr); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        total++; if (m_resp !== 4'h0) begin bad++; $display("FAIL to_early k=%0d got=%h exp=0", k, m_resp); end
      end else begin
        total++; if (m_resp !== 4'b0001 || m_err !== 4'b0001) begin bad++; $display("FAIL to_abort0 got=%h/%h exp=1/1", m_resp, m_err); end
        total++; if (m_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata got=%h exp=0", m_rdata); end
      end
    end
    tick();
    total++; if (s_req !== 1'b1 || s_addr !== 30'h22) begin bad++; $display("FAIL to_issue2 got=%b/%h exp=1/22", s_req, s_addr); end
    for (int k = 1; k <= 8; k++) begin
      tick();
    end
    total++; if (m_resp !== 4'b0100 || m_err !== 4'b0100) begin bad++; $display("FAIL to_abort2 got=%h/%h exp=4/4", m_resp, m_err); end
    s_rdata = 32'h0;
  endtask

  task automatic test_spurious();
    s_resp = 1'b1;
    tick();
    s_resp = 1'b0;
    total++; if (spurious_cnt !== 8'd1) begin bad++; $display("FAIL spur_one got=%0d exp=1", spurious_cnt); end
    total++; if (m_resp !== 4'h0) begin bad++; $display("FAIL spur_noresp got=%h exp=0", m_resp); end
    s_ack = 1'b1; s_resp = 1'b1;
    tick();
    total++; if (spurious_cnt !== 8'd3) begin bad++; $display("FAIL spur_both got=%0d exp=3", spurious_cnt); end
    for (int k = 0; k < 130; k++) begin
      tick();
    end
    s_ack = 1'b0; s_resp = 1'b0;
    total++; if (spurious_cnt !== 8'd255) begin bad++; $display("FAIL spur_sat got=%0d exp=255", spurious_cnt); end
    total++; if (m_ack !== 4'h0 || m_resp !== 4'h0) begin bad++; $display("FAIL spur_quiet got=%h/%h exp=0/0", m_ack, m_resp); end
  endtask

  task automatic test_reset_mid();
    m_req = 4'hF; m_cmd = '0;
    for (int i = 0; i < 4; i++) begin
      m_addr[i*AW +: AW] = AW'(32'h30 + i);
    end
    tick();
    m_req = '0;
    tick();
    total++; if (s_addr !== 30'h33 || m_full !== 4'b0111) begin bad++; $display("FAIL rm_wrap_pick got=%h/%h exp=33/7", s_addr, m_full); end
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    rst = 1'b1; s_resp = 1'b1;
    tick();
    s_resp = 1'b0;
    total++; if (m_full !== 4'h0) begin bad++; $display("FAIL rm_full got=%h exp=0", m_full); end
    total++; if ({m_ack, m_resp, m_err} !== 12'h0) begin bad++; $display("FAIL rm_strobes got=%h exp=0", {m_ack, m_resp, m_err}); end
    total++; if ({s_req, s_cmd, s_addr, s_wdata} !== '0) begin bad++; $display("FAIL rm_slave got=%b/%h exp=0", s_req, s_addr); end
    total++; if (spurious_cnt !== 8'd0) begin bad++; $display("FAIL rm_spur got=%0d exp=0", spurious_cnt); end
    rst = 1'b0;
    m_req = 4'b1000; m_addr[3*AW +: AW] = 30'h3F;
    tick();
    m_req = '0;
    tick();
    total++; if (s_req !== 1'b1 || s_addr !== 30'h3F) begin bad++; $display("FAIL rm_first_grant got=%b/%h exp=1/3f", s_req, s_addr); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_fairness();
    test_full_cell();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
